// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS main control FSM with registered ALU-control decode.
// Ports: clk/rst_n (async active-low); OpCode/FunctionCode sampled in DECODE;
// MemReady completes FETCH/MEMRD/MEMWR; datapath strobes PCWrite..PCSource,
// OperationCode to the ALU, Illegal pulse, State for debug.
module mips_multicycle_ctrl #(
  parameter int OPW = 6,
  parameter int FNW = 6,
  parameter int ACW = 4,
  parameter bit ENABLE_ADDI = 1'b1,
  parameter bit ENABLE_J = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] OpCode,
  input  logic [FNW-1:0] FunctionCode,
  input  logic           MemReady,
  output logic           PCWrite,
  output logic           PCWriteCond,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           MemtoReg,
  output logic           RegDst,
  output logic           RegWrite,
  output logic           AluSrcA,
  output logic [1:0]     AluSrcB,
  output logic [1:0]     PCSource,
  output logic [ACW-1:0] OperationCode,
  output logic           Illegal,
  output logic [3:0]     State
);
  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                         S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_RTYPEWB = 4'd7,
                         S_BRANCH = 4'd8, S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JUMP = 4'd11,
                         S_ILLEGAL = 4'd12;
  localparam logic [OPW-1:0] OP_LW = OPW'(6'b100011), OP_SW = OPW'(6'b101011), OP_R = OPW'(6'b000000),
                             OP_BEQ = OPW'(6'b000100), OP_ADDI = OPW'(6'b001000), OP_J = OPW'(6'b000010);
  localparam logic [FNW-1:0] F_ADD = FNW'(6'b100000), F_SUB = FNW'(6'b100010), F_AND = FNW'(6'b100100),
                             F_OR = FNW'(6'b100101), F_SLT = FNW'(6'b101010);
  localparam logic [ACW-1:0] A_AND = ACW'(4'b0000), A_OR = ACW'(4'b0001), A_ADD = ACW'(4'b0010),
                             A_SUB = ACW'(4'b0110), A_SLT = ACW'(4'b0111);
  logic [3:0]     r_state;
  logic [FNW-1:0] r_funct;
  logic           r_sw;
  logic [3:0]     w_next;
  logic [3:0]     w_dec_next;
  logic [ACW-1:0] w_fn_op;
  logic           w_fn_ok;
  logic           w_fetch;
  // Opcode is only meaningful while the IR holds the current instruction, i.e. in DECODE;
  // disabled optional opcodes fall through to ILLEGAL like any unknown opcode.
  assign w_dec_next = (OpCode == OP_LW || OpCode == OP_SW) ? S_MEMADR :
                      (OpCode == OP_R)                     ? S_EXEC :
                      (OpCode == OP_BEQ)                   ? S_BRANCH :
                      (OpCode == OP_ADDI && ENABLE_ADDI)   ? S_ADDIEX :
                      (OpCode == OP_J && ENABLE_J)         ? S_JUMP : S_ILLEGAL;
  assign w_fn_op = (r_funct == F_ADD) ? A_ADD :
                   (r_funct == F_SUB) ? A_SUB :
                   (r_funct == F_AND) ? A_AND :
                   (r_funct == F_OR)  ? A_OR :
                   (r_funct == F_SLT) ? A_SLT : '0;
  assign w_fn_ok = r_funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: w_next = w_dec_next;
      S_MEMADR: w_next = r_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = MemReady ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = w_fn_ok ? S_RTYPEWB : S_ILLEGAL;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_funct <= '0;
      r_sw    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_funct <= FunctionCode;
        r_sw    <= (OpCode == OP_SW);
      end
    end
  end
  assign w_fetch       = (r_state == S_FETCH);
  assign PCWrite       = (w_fetch && MemReady) || r_state == S_JUMP;
  assign IRWrite       = w_fetch && MemReady;
  assign PCWriteCond   = (r_state == S_BRANCH);
  assign IorD          = (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign MemRead       = w_fetch || (r_state == S_MEMRD);
  assign MemWrite      = (r_state == S_MEMWR);
  assign MemtoReg      = (r_state == S_MEMWB);
  assign RegDst        = (r_state == S_RTYPEWB);
  assign RegWrite      = (r_state == S_MEMWB) || (r_state == S_RTYPEWB) || (r_state == S_ADDIWB);
  assign AluSrcA       = (r_state == S_MEMADR) || (r_state == S_EXEC) || (r_state == S_BRANCH) || (r_state == S_ADDIEX);
  assign AluSrcB       = w_fetch ? 2'b01 :
                         (r_state == S_DECODE) ? 2'b11 :
                         (r_state == S_MEMADR || r_state == S_ADDIEX) ? 2'b10 : 2'b00;
  assign PCSource      = (r_state == S_BRANCH) ? 2'b01 : (r_state == S_JUMP) ? 2'b10 : 2'b00;
  // An EXEC with an unknown funct drives 0 while it heads to ILLEGAL.
  assign OperationCode = (w_fetch || r_state == S_DECODE || r_state == S_MEMADR || r_state == S_ADDIEX) ? A_ADD :
                         (r_state == S_EXEC)   ? w_fn_op :
                         (r_state == S_BRANCH) ? A_SUB : '0;
  assign Illegal       = (r_state == S_ILLEGAL);
  assign State         = r_state;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: randomized instruction stream checked against a path/table model.
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] OpCode = '0;
  logic [5:0] FunctionCode = '0;
  logic MemReady = 1'b0;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, AluSrcA, Illegal;
  logic [1:0] AluSrcB, PCSource;
  logic [3:0] OperationCode, State;
  logic b_PCWrite, b_PCWriteCond, b_IorD, b_MemRead, b_MemWrite, b_IRWrite, b_MemtoReg, b_RegDst, b_RegWrite, b_AluSrcA, b_Illegal;
  logic [1:0] b_AluSrcB, b_PCSource;
  logic [3:0] b_OperationCode, b_State;

  mips_multicycle_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .FunctionCode(FunctionCode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .AluSrcA(AluSrcA),
    .AluSrcB(AluSrcB), .PCSource(PCSource), .OperationCode(OperationCode), .Illegal(Illegal), .State(State));

  mips_multicycle_ctrl #(.ENABLE_ADDI(1'b0), .ENABLE_J(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .FunctionCode(FunctionCode), .MemReady(MemReady),
    .PCWrite(b_PCWrite), .PCWriteCond(b_PCWriteCond), .IorD(b_IorD), .MemRead(b_MemRead), .MemWrite(b_MemWrite),
    .IRWrite(b_IRWrite), .MemtoReg(b_MemtoReg), .RegDst(b_RegDst), .RegWrite(b_RegWrite), .AluSrcA(b_AluSrcA),
    .AluSrcB(b_AluSrcB), .PCSource(b_PCSource), .OperationCode(b_OperationCode), .Illegal(b_Illegal), .State(b_State));

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, pcsrc;
    logic [3:0] aop;
    logic ill;
    logic [3:0] st;
  } out_t;

  out_t act, exp;
  logic chk = 1'b0;
  int n_chk = 0, n_pass = 0, cyc = 0;
  logic [5:0] m_fn = '0;

  assign act = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                 AluSrcA, AluSrcB, PCSource, OperationCode, Illegal, State};

  function automatic logic [3:0] aluop(logic [5:0] f);
    case (f)
      6'h20: return 4'd2;
      6'h22: return 4'd6;
      6'h24: return 4'd0;
      6'h25: return 4'd1;
      6'h2A: return 4'd7;
      default: return 4'd0;
    endcase
  endfunction

  function automatic bit fn_ok(logic [5:0] f);
    return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  endfunction

  // Per-state strobe table straight from the control description.
  function automatic out_t exp_out(int st, logic rdy, logic [5:0] f);
    out_t o = '0;
    o.st = 4'(st);
    case (st)
      0:  begin o.mr = 1; o.srcb = 2'b01; o.aop = 4'd2; o.irw = rdy; o.pcw = rdy; end
      1:  begin o.srcb = 2'b11; o.aop = 4'd2; end
      2:  begin o.srca = 1; o.srcb = 2'b10; o.aop = 4'd2; end
      3:  begin o.mr = 1; o.iord = 1; end
      4:  begin o.rw = 1; o.m2r = 1; end
      5:  begin o.mw = 1; o.iord = 1; end
      6:  begin o.srca = 1; o.aop = aluop(f); end
      7:  begin o.rw = 1; o.rdst = 1; end
      8:  begin o.srca = 1; o.aop = 4'd6; o.pcwc = 1; o.pcsrc = 2'b01; end
      9:  begin o.srca = 1; o.srcb = 2'b10; o.aop = 4'd2; end
      10: o.rw = 1;
      11: begin o.pcw = 1; o.pcsrc = 2'b10; end
      12: o.ill = 1;
      default: ;
    endcase
    return o;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (chk) begin
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL cycle %0d state-model %0d: got %h want %h", cyc, exp.st, act, exp);
    end
  end

  task automatic lit(string name, logic [7:0] a, logic [7:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, a, e);
  endtask

  task automatic step(int st, logic rdy, logic [5:0] op, logic [5:0] fn);
    MemReady = rdy;
    OpCode = op;
    FunctionCode = fn;
    exp = exp_out(st, rdy, m_fn);
    chk = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic stepr(int st, logic rdy);
    step(st, rdy, 6'($urandom), 6'($urandom));
  endtask

  task automatic mem(int st);
    repeat ($urandom_range(0, 3)) stepr(st, 1'b0);
    stepr(st, 1'b1);
  endtask

  // Path of visible states per instruction class; waits inserted only where memory handshakes.
  task automatic run(logic [5:0] op, logic [5:0] fn);
    mem(0);
    step(1, 1'($urandom), op, fn);
    m_fn = fn;
    case (op)
      6'h23: begin stepr(2, 1'($urandom)); mem(3); stepr(4, 1'($urandom)); end
      6'h2B: begin stepr(2, 1'($urandom)); mem(5); end
      6'h00: begin stepr(6, 1'($urandom)); stepr(fn_ok(fn) ? 7 : 12, 1'($urandom)); end
      6'h04: stepr(8, 1'($urandom));
      6'h08: begin stepr(9, 1'($urandom)); stepr(10, 1'($urandom)); end
      6'h02: stepr(11, 1'($urandom));
      default: stepr(12, 1'($urandom));
    endcase
  endtask

  initial begin
    logic [5:0] fns [5];
    logic [5:0] op, fn;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    #2;
    lit("reset_state", 8'(State), 8'd0);
    lit("reset_illegal", 8'(Illegal), 8'd0);
    lit("reset_pcwrite", 8'(PCWrite), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(6'h23, 6'h00);
    for (int i = 0; i < 5; i++) run(6'h00, fns[i]);
    run(6'h3F, 6'h00);
    run(6'h00, 6'h07);
    run(6'h04, 6'h00);
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0: op = 6'h23;
        1: op = 6'h2B;
        2, 7: op = 6'h00;
        3: op = 6'h04;
        4: op = 6'h08;
        5: op = 6'h02;
        default: op = 6'($urandom);
      endcase
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run(op, fn);
    end
    chk = 1'b0;
    MemReady = 1'b1;
    OpCode = 6'h23;
    repeat (4) begin @(posedge clk); #1; end
    lit("memwb_state", 8'(State), 8'd4);
    lit("memwb_regwrite", 8'(RegWrite), 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    lit("async_rst_regwrite", 8'(RegWrite), 8'd0);
    lit("async_rst_memtoreg", 8'(MemtoReg), 8'd0);
    lit("async_rst_state", 8'(State), 8'd0);
    MemReady = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    OpCode = 6'h02;
    MemReady = 1'b1;
    @(posedge clk); #1;
    lit("j_decode", 8'(b_State), 8'd1);
    @(posedge clk); #1;
    lit("j_disabled_state", 8'(b_State), 8'd12);
    lit("j_disabled_illegal", 8'(b_Illegal), 8'd1);
    lit("j_disabled_pcwrite", 8'(b_PCWrite), 8'd0);
    lit("j_enabled_state", 8'(State), 8'd11);
    lit("j_enabled_pcwrite", 8'(PCWrite), 8'd1);
    OpCode = 6'h08;
    @(posedge clk); #1;
    lit("j_return_fetch", 8'(b_State), 8'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    lit("addi_disabled_illegal", 8'(b_Illegal), 8'd1);
    lit("addi_enabled_state", 8'(State), 8'd9);
    @(posedge clk); #1;
    lit("addi_disabled_fetch", 8'(b_State), 8'd0);
    lit("addi_enabled_wb", 8'(RegWrite), 8'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle MIPS main control FSM with an integrated, registered ALU-control decoder.
- Replaces the single-cycle combinational control unit and ALU control pair in the multicycle datapath.
- Sequences fetch, decode, execute, memory and writeback per instruction. Stretches memory states with a ready handshake.
- Flags illegal opcodes and illegal function codes, and suppresses all architectural writes for them.

Parameters:
- OPW, 6, opcode field width (Instr[31:26]).
- FNW, 6, function field width (Instr[5:0]).
- ACW, 4, ALU operation code width.
- ENABLE_ADDI, 1, decode opcode 001000 (addi); when 0, addi is treated as illegal.
- ENABLE_J, 1, decode opcode 000010 (j); when 0, j is treated as illegal.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- OpCode  in  OPW  instruction opcode; read only in state DECODE (from the IR)
- FunctionCode  in  FNW  R-format funct; read only in DECODE
- MemReady  in  1  memory handshake; completes the FETCH, MEMRD and MEMWR states
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU Zero
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  writeback data select: 1 = MDR
- RegDst  out  1  destination select: 1 = rd
- RegWrite  out  1  register file write
- AluSrcA  out  1  ALU A select: 0 = PC, 1 = regA
- AluSrcB  out  2  ALU B select: 00 = regB, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
- PCSource  out  2  next PC select: 00 = ALU, 01 = ALUOut, 10 = jump target
- OperationCode  out  ACW  ALU operation code
- Illegal  out  1  one-cycle pulse on an illegal instruction
- State  out  4  current state encoding, for debug

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0: state is FETCH, the latched funct register is 0, Illegal=0.
- Outputs: all strobes are decoded combinationally from state, plus MemReady where noted. Any strobe not listed for a state is 0.
- FETCH (0): MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, OperationCode=0010, PCSource=00. IRWrite and PCWrite are asserted only while MemReady=1. With MemReady=0 the FSM stays in FETCH and the PC does not change. With MemReady=1 it goes to DECODE.
- DECODE (1): AluSrcA=0, AluSrcB=11, OperationCode=0010 (branch target). FunctionCode is latched here. Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other opcode, or a disabled one -> ILLEGAL
- MEMADR (2): AluSrcA=1, AluSrcB=10, OperationCode=0010. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD (3): MemRead=1, IorD=1. Waits on MemReady, then goes to MEMWB.
- MEMWB (4): RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEMWR (5): MemWrite=1, IorD=1. MemWrite stays asserted until the MemReady cycle; then goes to FETCH.
- EXEC (6): AluSrcA=1, AluSrcB=00. OperationCode is taken from the latched funct:
  - 100000 -> 0010
  - 100010 -> 0110
  - 100100 -> 0000
  - 100101 -> 0001
  - 101010 -> 0111
  - a valid funct goes to RTYPEWB; any other funct goes to ILLEGAL.
- RTYPEWB (7): RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH.
- BRANCH (8): AluSrcA=1, AluSrcB=00, OperationCode=0110, PCWriteCond=1, PCSource=01. Goes to FETCH.
- ADDIEX (9): AluSrcA=1, AluSrcB=10, OperationCode=0010. Goes to ADDIWB.
- ADDIWB (10): RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH.
- JUMP (11): PCWrite=1, PCSource=10. Goes to FETCH.
- ILLEGAL (12): Illegal=1 for this single cycle, with no writes of any kind. Goes to FETCH.
- Unused encodings (13-15) go to FETCH with all strobes 0.
- Latency with MemReady tied high, in cycles: lw 5, sw 4, R-format 4, addi 4, beq 3, j 3, illegal 3.
- Opcode and funct changing outside DECODE have no effect.
- Reset asserted mid-instruction: all outputs drop to their FETCH/reset values immediately and no partial write completes.
- OperationCode is 0 (zero-extended to ACW) in states that do not use the ALU.

Test Plan:
- Reset release, MemReady=1, IR=lw (100011) -> states 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in the cycle of state 4.
- R-format with funct 101010 -> OperationCode=0111 in EXEC, RegDst=1 and RegWrite=1 in RTYPEWB, 4 cycles total. Repeat for each of the remaining four functs.
- sw with MemReady held 0 for 3 cycles in MEMWR -> MemWrite stays high 4 cycles, FSM then returns to FETCH. No IRWrite and no RegWrite at any point.
- FETCH with MemReady=0 for 2 cycles -> PCWrite and IRWrite stay 0, then pulse exactly once on the ready cycle.
- Opcode 111111, then R-format funct 000111 -> each gives one Illegal pulse, zero RegWrite/MemWrite/PCWrite* beyond FETCH, return to FETCH. With ENABLE_J=0, j also produces Illegal.
- rst_n pulled low during MEMWB -> RegWrite drops asynchronously and State=0. beq -> PCWriteCond=1 with OperationCode=0110 in state 8.
